pixel_packer: RTL and testbench

Downstream stage of the pixel XOR stage. It consumes the 8-bit `pixel_out`/`pixel_valid` stream and packs groups of three pixels into 24-bit words. The words are buffered in a small FIFO and presented on a valid/ready interface sized to match the 24-bit `dout`/`din` datapath of the DSP. It also drives `pix_req` back upstream as FIFO-space backpressure.

---
 rtl/pixel_packer_if.sv | 15 +
 rtl/pixel_packer.sv | 140 ++++++++++++++
 tb/tb_pixel_packer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_packer_if.sv
// Generic valid/ready stream bundle.
//   data  - payload, WIDTH bits
//   valid - payload is valid this cycle
//   ready - sink can take the payload (or, upstream, may send)
// master drives data/valid and samples ready; slave is the mirror.
interface pixel_packer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pixel_packer.sv
// Packs an 8-bit pixel stream into 24-bit words (first pixel in [7:0]) and
// buffers them in a DEPTH-word FIFO presented on a valid/ready port.
// Ports:
//   clk, rstn     - clock; asynchronous reset, asserted high
//   en            - pixel accept enable (flush and pop ignore it)
//   flush         - one-cycle pulse, emits a pending partial word padded with PAD
//   clr_ovf       - clears the sticky overflow flag
//   pix           - pixel stream in: data=pixel_in, valid=pixel_valid, ready=pix_req
//   word          - word stream out: data=word_out, valid=word_valid, ready=word_ready
//   level         - words held in the FIFO
//   phase         - bytes held in the assembly register (0..2)
//   overflow      - sticky, a completed word was dropped on a full FIFO
module pixel_packer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  PAD   = 8'h00
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     clr_ovf,
  pixel_packer_if.slave            pix,
  pixel_packer_if.master           word,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               phase,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] Full       = LW'(DEPTH);
  localparam logic [LW-1:0] AlmostFull = LW'(DEPTH - 1);

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    phase_q, phase_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    lane0_q, lane0_n;
  logic [7:0]    lane1_q, lane1_n;

  logic          accept;
  logic          completes;
  logic          flush_push;
  logic [1:0]    phase_after;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic [23:0]   push_word;

  always_comb begin
    accept      = pix.valid & en;
    lane0_n     = lane0_q;
    lane1_n     = lane1_q;
    phase_after = phase_q;
    completes   = accept && (phase_q == 2'd2);

    if (accept) begin
      unique case (phase_q)
        2'd0:    lane0_n = pix.data;
        2'd1:    lane1_n = pix.data;
        default: ;
      endcase
      phase_after = phase_q + 2'd1;
    end

    // Flush sees the state after any same-cycle pixel; a completing pixel
    // already pushes, so the flush has nothing left to emit.
    flush_push = flush && !completes && (phase_after != 2'd0);

    if (completes) begin
      push_word = {pix.data, lane1_q, lane0_q};
    end else if (phase_after == 2'd1) begin
      push_word = {PAD, PAD, lane0_n};
    end else begin
      push_word = {PAD, lane1_n, lane0_n};
    end

    push    = completes | flush_push;
    pop     = (level_q != '0) & word.ready;
    // A same-cycle pop frees the slot the push needs.
    push_ok = push && ((level_q < Full) || pop);

    phase_d = (completes || flush_push) ? 2'd0 : phase_after;

    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      phase_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  // Datapath storage is not reset; phase/level gate its meaning.
  always_ff @(posedge clk) begin
    lane0_q <= lane0_n;
    lane1_q <= lane1_n;
    if (push_ok) begin
      mem[wr_ptr_q] <= push_word;
    end
  end

  always_comb begin
    word.valid = (level_q != '0);
    word.data  = word.valid ? mem[rd_ptr_q] : 24'h0;
    // Drops with one slot still free so a source can finish one more word.
    pix.ready  = ~rstn & (level_q < AlmostFull);
    level      = level_q;
    phase      = phase_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_pixel_packer.sv
module tb_pixel_packer;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       flush;
  logic       clr_ovf;
  logic [2:0] level;
  logic [1:0] phase;
  logic       overflow;

  int checks;
  int failures;

  pixel_packer_if #(.WIDTH(8))  pix_bus ();
  pixel_packer_if #(.WIDTH(24)) word_bus ();

  pixel_packer #(
    .DEPTH (4),
    .PAD   (8'h00)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .flush    (flush),
    .clr_ovf  (clr_ovf),
    .pix      (pix_bus),
    .word     (word_bus),
    .level    (level),
    .phase    (phase),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        vld;
    logic [7:0]  pix;
    logic        fl;
    logic        clr;
    logic        rdy;
    logic        wv;
    logic [23:0] wout;
    logic [2:0]  lvl;
    logic [1:0]  ph;
    logic        ovf;
    logic        req;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic v, input logic [7:0] p, input logic f,
                     input logic c, input logic r, input logic wv, input logic [23:0] wout,
                     input logic [2:0] lvl, input logic [1:0] ph, input logic ovf,
                     input logic req);
    vec_t x;
    x.en = e; x.vld = v; x.pix = p; x.fl = f; x.clr = c; x.rdy = r;
    x.wv = wv; x.wout = wout; x.lvl = lvl; x.ph = ph; x.ovf = ovf; x.req = req;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic wv, input logic [23:0] wout,
                             input logic [2:0] lvl, input logic [1:0] ph, input logic ovf,
                             input logic req);
    chk({tag, ".word_valid"}, 32'(word_bus.valid), 32'(wv));
    chk({tag, ".word_out"},   32'(word_bus.data),  32'(wout));
    chk({tag, ".level"},      32'(level),          32'(lvl));
    chk({tag, ".phase"},      32'(phase),          32'(ph));
    chk({tag, ".overflow"},   32'(overflow),       32'(ovf));
    chk({tag, ".pix_req"},    32'(pix_bus.ready),  32'(req));
  endtask

  task automatic step(input logic e, input logic v, input logic [7:0] p, input logic f,
                      input logic c, input logic r);
    en = e; pix_bus.valid = v; pix_bus.data = p; flush = f; clr_ovf = c;
    word_bus.ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Six pixels, consumer always ready.
    add(1,1,8'h01,0,0,1, 0,24'h0,0,1,0,1);
    add(1,1,8'h02,0,0,1, 0,24'h0,0,2,0,1);
    add(1,1,8'h03,0,0,1, 1,24'h030201,1,0,0,1);
    add(1,1,8'h04,0,0,1, 0,24'h0,0,1,0,1);
    add(1,1,8'h05,0,0,1, 0,24'h0,0,2,0,1);
    add(1,1,8'h06,0,0,1, 1,24'h060504,1,0,0,1);
    add(1,0,8'h00,0,0,1, 0,24'h0,0,0,0,1);
    // Partial word flush, then a flush with nothing pending.
    add(1,1,8'hAA,0,0,0, 0,24'h0,0,1,0,1);
    add(1,1,8'hBB,0,0,0, 0,24'h0,0,2,0,1);
    add(1,0,8'h00,1,0,0, 1,24'h00BBAA,1,0,0,1);
    add(1,0,8'h00,1,0,0, 1,24'h00BBAA,1,0,0,1);
    add(1,0,8'h00,0,0,1, 0,24'h0,0,0,0,1);
    // Fill to full and beyond with the consumer stalled.
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 3; b++) begin
        int l;
        l = (b == 2) ? w + 1 : w;
        if (l > 4) l = 4;
        add(1, 1, 8'h10 + 8'(3 * w + b), 0, 0, 0,
            l != 0, (l != 0) ? 24'h121110 : 24'h0, 3'(l),
            (b == 2) ? 2'd0 : 2'(b + 1), (w == 4) && (b == 2), l < 3);
      end
    end
    add(1,0,8'h00,0,1,0, 1,24'h121110,4,0,0,0);
    // Full FIFO: third pixel lands together with a pop.
    add(1,1,8'h20,0,0,0, 1,24'h121110,4,1,0,0);
    add(1,1,8'h21,0,0,0, 1,24'h121110,4,2,0,0);
    add(1,1,8'h22,0,0,1, 1,24'h151413,4,0,0,0);
    add(1,0,8'h00,0,0,1, 1,24'h181716,3,0,0,0);
    add(1,0,8'h00,0,0,1, 1,24'h1B1A19,2,0,0,1);
    add(1,0,8'h00,0,0,1, 1,24'h222120,1,0,0,1);
    add(1,0,8'h00,0,0,1, 0,24'h0,0,0,0,1);
    // Disabled accept; pixel plus flush; flush with a completing pixel.
    add(0,1,8'h11,0,0,0, 0,24'h0,0,0,0,1);
    add(1,1,8'h22,1,0,0, 1,24'h000022,1,0,0,1);
    add(1,0,8'h00,0,0,1, 0,24'h0,0,0,0,1);
    add(1,1,8'h31,0,0,0, 0,24'h0,0,1,0,1);
    add(1,1,8'h32,0,0,0, 0,24'h0,0,2,0,1);
    add(1,1,8'h33,1,0,0, 1,24'h333231,1,0,0,1);
    add(1,0,8'h00,0,0,0, 1,24'h333231,1,0,0,1);
    add(1,0,8'h00,0,0,1, 0,24'h0,0,0,0,1);
    add(1,1,8'h41,0,0,0, 0,24'h0,0,1,0,1);
    add(1,1,8'h42,1,0,0, 1,24'h004241,1,0,0,1);
    add(1,0,8'h00,0,0,1, 0,24'h0,0,0,0,1);
    add(1,0,8'h00,0,0,1, 0,24'h0,0,0,0,1);

    rstn = 1'b1;
    en = 1'b0; pix_bus.valid = 1'b0; pix_bus.data = 8'h00; flush = 1'b0; clr_ovf = 1'b0;
    word_bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 24'h0, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].vld, vecs[i].pix, vecs[i].fl, vecs[i].clr, vecs[i].rdy);
      check_state($sformatf("vec%0d", i), vecs[i].wv, vecs[i].wout, vecs[i].lvl,
                  vecs[i].ph, vecs[i].ovf, vecs[i].req);
    end

    // Overflow: set wins over a same-cycle clear; a dropped flush also sets it.
    for (int i = 0; i < 14; i++) step(1, 1, 8'(8'h60 + i), 0, 0, 0);
    step(1, 1, 8'h6E, 0, 1, 0);
    check_state("ovf_set_wins", 1, 24'h626160, 4, 0, 1, 0);
    step(1, 0, 8'h00, 0, 1, 0);
    check_state("ovf_clear", 1, 24'h626160, 4, 0, 0, 0);
    step(1, 1, 8'h55, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    check_state("flush_drop", 1, 24'h626160, 4, 0, 1, 0);
    step(1, 0, 8'h00, 0, 1, 1);
    check_state("drain0", 1, 24'h656463, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, 0, 1);
    check_state("drained", 0, 24'h0, 0, 0, 0, 1);

    // Asynchronous reset mid-word with two words queued.
    for (int i = 0; i < 8; i++) step(1, 1, 8'(8'h70 + i), 0, 0, 0);
    check_state("pre_reset", 1, 24'h727170, 2, 2, 0, 1);
    rstn = 1'b1;
    #1;
    check_state("async_reset", 0, 24'h0, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b0;
    step(1, 1, 8'h07, 0, 0, 0);
    step(1, 1, 8'h08, 0, 0, 0);
    step(1, 1, 8'h09, 0, 0, 0);
    check_state("post_reset", 1, 24'h090807, 1, 0, 0, 1);
    step(1, 0, 8'h00, 0, 0, 1);
    check_state("post_reset_pop", 0, 24'h0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
